// File: rtl/mem_ctrl.sv
// Single-port RAM arbiter: memory-stage loads/stores take the 8-bit port from
// the fetch stage and are serialised into byte accesses, little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [7:0]        if_data_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_width_i,
  input  logic              mem_signed_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_busy_o,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [1:0]        width_reg;
  logic              sgn_reg;
  logic [31:0]       wdata_reg;
  logic [23:0]       lanes_reg;
  logic [31:0]       rdata_reg;
  logic              done_reg;

  logic [1:0]        last_cnt;
  logic              last;
  logic [1:0]        lane;
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic              unused_if_req;

  // fetch request is informational; the port is always handed out
  assign unused_if_req = if_req_i;

  assign if_data_o   = ram_din_i;
  assign mem_rdata_o = rdata_reg;
  assign mem_done_o  = done_reg;
  assign mem_busy_o  = mem_req_i & ~done_reg;

  assign last_cnt = (width_reg == 2'b00) ? 2'd0 : (width_reg == 2'b01) ? 2'd1 : 2'd3;
  assign last     = (cnt_reg == last_cnt);
  assign lane     = cnt_reg - 2'd1;

  // top lane arrives straight from the RAM in the RD_TAIL cycle
  always_comb begin
    raw = {8'h00, lanes_reg};
    raw[{last_cnt, 3'b000} +: 8] = ram_din_i;
    case (width_reg)
      2'b00:   ext = {{24{sgn_reg & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{sgn_reg & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    ram_addr_o = if_addr_i;
    ram_dout_o = 8'h00;
    ram_wr_o   = 1'b0;
    if_stall_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req_i && !done_reg)
          state_next = mem_we_i ? WR : RD;
      end
      RD: begin
        ram_addr_o = base_reg + ADDR_W'(cnt_reg);
        if_stall_o = 1'b1;
        if (last)
          state_next = RD_TAIL;
      end
      RD_TAIL: begin
        state_next = IDLE;
      end
      WR: begin
        ram_addr_o = base_reg + ADDR_W'(cnt_reg);
        ram_dout_o = wdata_reg[{cnt_reg, 3'b000} +: 8];
        ram_wr_o   = 1'b1;
        if_stall_o = 1'b1;
        if (last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      base_reg  <= '0;
      width_reg <= 2'b00;
      sgn_reg   <= 1'b0;
      wdata_reg <= 32'h0;
      lanes_reg <= 24'h0;
      rdata_reg <= 32'h0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_req_i && !done_reg) begin
            base_reg  <= mem_addr_i;
            width_reg <= mem_width_i;
            sgn_reg   <= mem_signed_i;
            wdata_reg <= mem_wdata_i;
            cnt_reg   <= 2'd0;
          end
        end
        RD: begin
          // byte addressed last cycle is on ram_din_i now
          if (cnt_reg != 2'd0)
            lanes_reg[{lane, 3'b000} +: 8] <= ram_din_i;
          cnt_reg <= cnt_reg + 2'd1;
        end
        RD_TAIL: begin
          rdata_reg <= ext;
          done_reg  <= 1'b1;
        end
        WR: begin
          cnt_reg <= cnt_reg + 2'd1;
          if (last)
            done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl: byte RAM model with 1-cycle read latency,
// shadow memory as reference, timing derived from the cycle-numbering rules.
module tb_mem_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [7:0]    if_data_o;
  logic          if_stall_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [1:0]    mem_width_i;
  logic          mem_signed_i;
  logic [31:0]   mem_wdata_i;
  logic [31:0]   mem_rdata_o;
  logic          mem_done_o;
  logic          mem_busy_o;
  logic [7:0]    ram_din_i;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_dout_o;
  logic          ram_wr_o;

  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  rd_byte;
  logic [31:0] last_rdata;
  logic [31:0] obs;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_width_i(mem_width_i), .mem_signed_i(mem_signed_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_busy_o(mem_busy_o),
    .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o)
  );

  // RAM: read data registered one cycle after the address, write on the edge
  initial begin : ram_model
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 5);
    ram_din_i = 8'h00;
    forever begin
      @(posedge clk);
      rd_byte = ram[ram_addr_o[11:0]];
      if (ram_wr_o) ram[ram_addr_o[11:0]] = ram_dout_o;
      ram_din_i <= rd_byte;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] w, input logic sg);
    logic [31:0] v;
    logic [31:0] a;
    int n;
    n = nbytes(w);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v = v | (32'(ref_mem[a[11:0]]) << (8 * i));
    end
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Caller is just after a rising edge; this cycle is cycle 0 of the request.
  task automatic run_mem(input logic we, input logic [31:0] addr, input logic [1:0] w,
                         input logic sg, input logic [31:0] wd, input bit hold,
                         output logic [31:0] result);
    int n;
    int done_cyc;
    bit seen;
    logic [31:0] exp;
    logic [31:0] a;
    n = nbytes(w);
    done_cyc = we ? n + 1 : n + 2;
    exp = ref_load(addr, w, sg);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
    mem_width_i = w; mem_signed_i = sg; mem_wdata_i = wd;
    if_addr_i = $urandom;
    @(negedge clk);
    check("busy_c0", mem_busy_o, 1);
    check("stall_c0", if_stall_o, 0);
    seen = 0;
    result = 32'hx;
    for (int c = 1; c <= n + 3 && !seen; c++) begin
      @(posedge clk); #1;
      if_addr_i = $urandom;
      @(negedge clk);
      check("stall", if_stall_o, (c <= n) ? 1 : 0);
      check("done", mem_done_o, (c == done_cyc) ? 1 : 0);
      if (c <= n) begin
        check("ram_addr", ram_addr_o, addr + 32'(c - 1));
        check("ram_wr", ram_wr_o, we);
        if (we) check("ram_dout", ram_dout_o, wd[8*(c-1) +: 8]);
      end else begin
        check("ram_addr_idle", ram_addr_o, if_addr_i);
        check("ram_wr_idle", ram_wr_o, 0);
      end
      if (mem_done_o) begin
        seen = 1;
        result = mem_rdata_o;
        check("busy_done", mem_busy_o, 0);
        check(we ? "rdata_keep" : "rdata", mem_rdata_o, we ? last_rdata : exp);
        if (!hold) mem_req_i = 1'b0;
      end
    end
    check("done_seen", seen, 1);
    mem_req_i = hold ? mem_req_i : 1'b0;
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    @(negedge clk);
    check("no_restart_stall", if_stall_o, 0);
    check("no_restart_wr", ram_wr_o, 0);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        ref_mem[a[11:0]] = wd[8*i +: 8];
      end
    end else begin
      last_rdata = exp;
    end
    $display("txn %s addr=%h bytes=%0d signed=%0d data=%h result=%h",
             we ? "store" : "load", addr, n, sg, wd, result);
    @(posedge clk); #1;
  endtask

  task automatic idle_fetch(input int cycles);
    logic [31:0] prev;
    prev = 32'h0;
    for (int i = 0; i < cycles; i++) begin
      if_addr_i = $urandom;
      @(negedge clk);
      check("fetch_addr", ram_addr_o, if_addr_i);
      check("fetch_stall", if_stall_o, 0);
      if (i > 0) check("fetch_data", 32'(if_data_o), 32'(ref_mem[prev[11:0]]));
      prev = if_addr_i;
      @(posedge clk); #1;
    end
    $display("txn fetch cycles=%0d", cycles);
  endtask

  initial begin : main
    logic [31:0] fptr, pend_a, inst;
    bit pend_v, issued, col_done;
    int got, stalls, idx;
    logic [1:0] rw;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 5);
    last_rdata = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 32'h0; mem_width_i = 2'b00; mem_signed_i = 1'b0; mem_wdata_i = 32'h0;

    #1;
    check("rst_done", mem_done_o, 0);
    check("rst_rdata", mem_rdata_o, 32'h0);
    check("rst_stall", if_stall_o, 0);
    check("rst_wr", ram_wr_o, 0);
    check("rst_addr", ram_addr_o, if_addr_i);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    idle_fetch(16);

    run_mem(1, 32'h100, 2'b10, 0, 32'h4433_2211, 0, obs);
    run_mem(1, 32'h040, 2'b10, 0, 32'h00A0_0093, 0, obs);
    run_mem(1, 32'h010, 2'b00, 0, 32'h0000_0080, 0, obs);
    run_mem(1, 32'h020, 2'b01, 0, 32'h0000_8234, 0, obs);
    run_mem(1, 32'h200, 2'b10, 0, 32'hDEAD_BEEF, 0, obs);

    run_mem(0, 32'h100, 2'b10, 0, 32'h0, 0, obs);
    check("word_load", obs, 32'h4433_2211);
    run_mem(0, 32'h010, 2'b00, 1, 32'h0, 0, obs);
    check("byte_signed", obs, 32'hFFFF_FF80);
    run_mem(0, 32'h010, 2'b00, 0, 32'h0, 0, obs);
    check("byte_unsigned", obs, 32'h0000_0080);
    run_mem(0, 32'h020, 2'b01, 1, 32'h0, 0, obs);
    check("half_signed", obs, 32'hFFFF_8234);
    run_mem(0, 32'h200, 2'b10, 0, 32'h0, 0, obs);
    check("store_readback", obs, 32'hDEAD_BEEF);

    run_mem(1, 32'h050, 2'b00, 0, 32'h0000_005A, 1, obs);

    // fetch stage model: re-presents an address while stalled, captures the
    // byte one cycle after an address was serviced
    fptr = 32'h40; pend_a = 32'h0; inst = 32'h0;
    pend_v = 0; issued = 0; col_done = 0; got = 0; stalls = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if_addr_i = fptr;
      if (!issued && fptr == 32'h42) begin
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100;
        mem_width_i = 2'b10; mem_signed_i = 1'b0;
        issued = 1;
      end
      @(negedge clk);
      if (if_stall_o) stalls++;
      if (mem_done_o) begin
        check("col_rdata", mem_rdata_o, 32'h4433_2211);
        mem_req_i = 1'b0;
        col_done = 1;
      end
      if (pend_v) begin
        idx = int'(pend_a - 32'h40);
        inst[8*idx +: 8] = if_data_o;
        got++;
      end
      if (!if_stall_o) begin
        pend_v = 1; pend_a = fptr; fptr = fptr + 32'h1;
      end else begin
        pend_v = 0;
      end
      @(posedge clk); #1;
    end
    mem_req_i = 1'b0;
    check("col_inst", inst, 32'h00A0_0093);
    check("col_stalls", stalls, 4);
    check("col_done", col_done, 1);
    last_rdata = 32'h4433_2211;
    $display("txn collision inst=%h stalls=%0d", inst, stalls);
    @(posedge clk); #1;

    // reset two bytes into a word store
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300;
    mem_width_i = 2'b10; mem_signed_i = 1'b0; mem_wdata_i = 32'hCAFE_BABE;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_wr", ram_wr_o, 1);
    rst = 1'b0;
    mem_req_i = 1'b0;
    #1;
    check("rst_wr_drop", ram_wr_o, 0);
    check("rst_stall_drop", if_stall_o, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", mem_done_o, 0);
    end
    rst = 1'b1;
    #1;
    check("rst_rdata_clr", mem_rdata_o, 32'h0);
    check("rst_idle_addr", ram_addr_o, if_addr_i);
    ref_mem[12'h300] = 8'hBE;
    ref_mem[12'h301] = 8'hBA;
    last_rdata = 32'h0;
    $display("txn reset-mid-store addr=00000300");
    @(posedge clk); #1;
    run_mem(0, 32'h300, 2'b10, 0, 32'h0, 0, obs);
    check("partial_store", obs[15:0], 32'h0000_BABE);

    run_mem(0, 32'hFFFF_FFFE, 2'b10, 0, 32'h0, 0, obs);

    for (int t = 0; t < 40; t++) begin
      rw = 2'($urandom_range(0, 3));
      run_mem(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), rw,
              1'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)), obs);
    end

    idle_fetch(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
